// File: rtl/alu_arbitro.sv
// Two-requester sequencer for a shared combinational ALU; shifts iterate the ALU's shift-by-one.
// Define ALU_ARB_RR_EN for round-robin arbitration (default: requester 0 has fixed priority).
`timescale 1ns/1ps
module alu_arbitro #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       op0,
  input  logic [3:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] res0,
  output logic [WIDTH-1:0] res1,
  output logic             err,
  output logic             ocupado,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_resultado
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic [WIDTH-1:0] res0_q, res0_d;
  logic [WIDTH-1:0] res1_q, res1_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             err_q, err_d;
  logic             sel;
`ifdef ALU_ARB_RR_EN
  logic             rr_q, rr_d;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
`ifdef ALU_ARB_RR_EN
    rr_d    = rr_q;
    // rr_q=1 hands a tie to requester 1
    sel     = req1 & (~req0 | rr_q);
`else
    sel     = ~req0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          gnt_d   = sel;
          op_d    = sel ? op1 : op0;
          acc_d   = sel ? a1 : a0;
          b_d     = sel ? b1 : b0;
          cnt_d   = sel ? b1[SHW-1:0] : b0[SHW-1:0];
          flag_d  = 1'b0;
          state_d = S_EXEC;
`ifdef ALU_ARB_RR_EN
          rr_d    = ~sel;
`endif
        end
      end
      S_EXEC: begin
        if (op_q > 4'd6) begin
          acc_d   = '0;
          flag_d  = 1'b1;
          state_d = S_DONE;
        end else if (op_q == 4'd4 || op_q == 4'd5) begin
          // Zero-count shifts skip the ALU and keep the original operand
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            alu_a  = acc_q;
            alu_b  = b_q;
            alu_op = op_q;
            acc_d  = alu_resultado;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == SHW'(1)) state_d = S_DONE;
          end
        end else begin
          alu_a   = acc_q;
          alu_b   = b_q;
          alu_op  = op_q;
          acc_d   = alu_resultado;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (gnt_q) begin
          res1_d = acc_q;
          ack1_d = 1'b1;
        end else begin
          res0_d = acc_q;
          ack0_d = 1'b1;
        end
        err_d   = flag_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      op_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      res0_q  <= '0;
      res1_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
`ifdef ALU_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign res0    = res0_q;
  assign res1    = res1_q;
  assign err     = err_q;
  assign ocupado = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbitro.sv
// Directed bench for alu_arbitro with a behavioural model of the shared ALU.
`timescale 1ns/1ps
module tb_alu_arbitro;
  logic        clk, rst;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        ack0, ack1, err, ocupado;
  logic [31:0] res0, res1, alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;
  int checks = 0;
  int errors = 0;

  alu_arbitro #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ack0(ack0), .ack1(ack1),
    .res0(res0), .res1(res1), .err(err), .ocupado(ocupado),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_resultado(alu_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      4'd0: alu_res = alu_a + alu_b;
      4'd1: alu_res = alu_a & alu_b;
      4'd2: alu_res = {31'b0, alu_a == alu_b};
      4'd3: alu_res = {31'b0, alu_a > alu_b};
      4'd4: alu_res = alu_a << 1;
      4'd5: alu_res = alu_a >> 1;
      4'd6: alu_res = alu_a - alu_b;
      default: alu_res = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input bit who, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res_exp,
                       input logic err_exp, input int lat_exp);
    int lat;
    bit other;
    logic [3:0] aop_exp;
    aop_exp = (op > 4'd6 || ((op == 4'd4 || op == 4'd5) && b[4:0] == 5'd0)) ? 4'd0 : op;
    @(negedge clk);
    if (who) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else     begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    lat = -1;
    other = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("busy_exec", {31'b0, ocupado}, 32'd1);
        chk("alu_op_exec", {28'b0, alu_op}, {28'b0, aop_exp});
      end
      if (who ? ack0 : ack1) other = 1'b1;
      if (who ? ack1 : ack0) begin lat = n; break; end
    end
    if (who) req1 = 1'b0; else req0 = 1'b0;
    chk("latency", 32'(lat), 32'(lat_exp));
    chk("res", who ? res1 : res0, res_exp);
    chk("err", {31'b0, err}, {31'b0, err_exp});
    chk("other_ack", {31'b0, other}, 32'd0);
    @(negedge clk);
    chk("ack_one_cycle", {31'b0, who ? ack1 : ack0}, 32'd0);
    chk("err_one_cycle", {31'b0, err}, 32'd0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit ord[4];
    bit exp_ord[4];
    int got;
    bit ack_seen;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack0", {31'b0, ack0}, 32'd0);
    chk("rst_ack1", {31'b0, ack1}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_res0", res0, 32'd0);
    chk("rst_res1", res1, 32'd0);
    chk("rst_busy", {31'b0, ocupado}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
    rst = 1'b0;

    do_op(1'b0, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 2);
    do_op(1'b1, 4'd4, 32'd1, 32'd3, 32'd8, 1'b0, 4);
    do_op(1'b1, 4'd4, 32'd1, 32'd0, 32'd1, 1'b0, 2);
    do_op(1'b0, 4'd6, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 2);
    do_op(1'b0, 4'd15, 32'd3, 32'd5, 32'd0, 1'b1, 2);
    do_op(1'b1, 4'd5, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 32);
    do_op(1'b0, 4'd3, 32'd9, 32'd2, 32'd1, 1'b0, 2);
    chk("res1_untouched", res1, 32'd1);

    // Both requesters held high from a fresh reset
    reset_pulse();
`ifdef ALU_ARB_RR_EN
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    req0 = 1'b1; op0 = 4'd0; a0 = 32'd1;  b0 = 32'd1;
    req1 = 1'b1; op1 = 4'd0; a1 = 32'd10; b1 = 32'd10;
    got = 0;
    ord = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int n = 0; n < 100 && got < 4; n++) begin
      @(negedge clk);
      if (ack0) begin ord[got] = 1'b0; got++; chk("both_res0", res0, 32'd2); end
      else if (ack1) begin ord[got] = 1'b1; got++; chk("both_res1", res1, 32'd20); end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("both_count", 32'(got), 32'd4);
    for (int i = 0; i < 4; i++) chk("grant_order", {31'b0, ord[i]}, {31'b0, exp_ord[i]});
    repeat (3) @(negedge clk);

    // Reset during the second iteration of a shift by 10
    req1 = 1'b1; op1 = 4'd4; a1 = 32'd1; b1 = 32'd10;
    @(negedge clk);
    @(negedge clk);
    chk("shift_iter_op", {28'b0, alu_op}, 32'd4);
    chk("shift_iter_a", alu_a, 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, ocupado}, 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_alu_op", {28'b0, alu_op}, 32'd0);
    chk("midrst_res0", res0, 32'd0);
    chk("midrst_res1", res1, 32'd0);
    req1 = 1'b0;
    ack_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ack0 | ack1) ack_seen = 1'b1;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ack0 | ack1) ack_seen = 1'b1;
    end
    chk("midrst_no_ack", {31'b0, ack_seen}, 32'd0);
    do_op(1'b1, 4'd2, 32'd9, 32'd9, 32'd1, 1'b0, 2);
    chk("res0_after_rst", res0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
